// File: rtl/seq_shifter.sv
// Multi-cycle shift unit: SHL / SHR logical / SHR arithmetic / ROTL.
// Each cycle shifts by up to STEP positions, with a valid/ready handshake on both ends.
module seq_shifter #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] sh_amt,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             busy
);

    localparam int LW = $clog2(WIDTH);
    localparam int CW = LW + 1;  // wide enough to hold WIDTH itself
    localparam logic [CW-1:0]    WIDTH_C = CW'(WIDTH);
    localparam logic [CW-1:0]    STEP_C  = CW'(STEP);
    localparam logic [WIDTH-1:0] WIDTH_W = WIDTH'(WIDTH);
    localparam logic [WIDTH-1:0] ONES    = '1;

    localparam logic [1:0] M_SHL  = 2'b00;
    localparam logic [1:0] M_SHR  = 2'b01;
    localparam logic [1:0] M_SRA  = 2'b10;
    localparam logic [1:0] M_ROTL = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  work_q,  work_d;
    logic [CW-1:0]     cnt_q,   cnt_d;
    logic [1:0]        mode_q,  mode_d;
    logic              sign_q,  sign_d;
    logic [WIDTH-1:0]  d_q,     d_d;

    logic [CW-1:0]     k;
    logic [CW-1:0]     cnt_acc;
    logic [WIDTH-1:0]  fill;
    logic [WIDTH-1:0]  shifted;

    // One step of the working register by k = min(cnt, STEP).
    always_comb begin
        k       = (cnt_q < STEP_C) ? cnt_q : STEP_C;
        fill    = ~(ONES >> k);
        shifted = work_q;
        case (mode_q)
            M_SHL:   shifted = work_q << k;
            M_SHR:   shifted = work_q >> k;
            M_SRA:   shifted = (work_q >> k) | (sign_q ? fill : '0);
            M_ROTL:  shifted = (work_q << k) | (work_q >> (WIDTH_C - k));
            default: shifted = work_q;
        endcase
    end

    // Rotate wraps modulo WIDTH; the other modes saturate at WIDTH.
    always_comb begin
        if (mode == M_ROTL)
            cnt_acc = CW'(sh_amt[LW-1:0]);
        else if (sh_amt >= WIDTH_W)
            cnt_acc = WIDTH_C;
        else
            cnt_acc = sh_amt[CW-1:0];
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        sign_d  = sign_q;
        d_d     = d_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    work_d = a;
                    mode_d = mode;
                    sign_d = a[WIDTH-1];
                    cnt_d  = cnt_acc;
                    if (cnt_acc == '0) begin
                        d_d     = a;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                work_d = shifted;
                cnt_d  = cnt_q - k;
                if (cnt_q == k) begin
                    d_d     = shifted;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= S_IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            mode_q  <= '0;
            sign_q  <= 1'b0;
            d_q     <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            sign_q  <= sign_d;
            d_q     <= d_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_SHIFT) || (state_q == S_DONE);
    assign d         = d_q;

endmodule
